// File: rtl/key_event_decoder.sv
// Turns the debounced active-low 3-key bus into per-key press/release/long/repeat
// pulses plus a merged press/repeat strobe carrying the lowest active key index.

module key_event_lane #(
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_o,
  output logic rel_o,
  output logic long_o,
  output logic rpt_o
);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;
  logic               long_q, long_d;
  logic               rpt_q, rpt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_n) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        // release beats the terminal count when both land in the same cycle
        if (key_n) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (cnt_q == CNT_W'(LONG_TIME - 1)) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (key_n) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (cnt_q == CNT_W'(REPEAT_TIME - 1)) begin
          cnt_d = '0;
          rpt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign long_o  = long_q;
  assign rpt_o   = rpt_q;
endmodule

module key_event_decoder #(
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_value,
  output logic [2:0] key_press,
  output logic [2:0] key_release,
  output logic [2:0] key_long,
  output logic [2:0] key_repeat,
  output logic       key_evt,
  output logic [1:0] key_id
);
  for (genvar i = 0; i < 3; i++) begin : g_lane
    key_event_lane #(
      .LONG_TIME  (LONG_TIME),
      .REPEAT_TIME(REPEAT_TIME),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key_value[i]),
      .press_o(key_press[i]),
      .rel_o  (key_release[i]),
      .long_o (key_long[i]),
      .rpt_o  (key_repeat[i])
    );
  end

  logic [2:0] pr;
  logic       key_evt_q, key_evt_d;
  logic [1:0] key_id_q, key_id_d;

  assign pr = key_press | key_repeat;

  // strobe follows the registered pulses by one cycle; index holds when idle
  always_comb begin
    key_evt_d = |pr;
    key_id_d  = key_id_q;
    if (pr[0])      key_id_d = 2'd0;
    else if (pr[1]) key_id_d = 2'd1;
    else if (pr[2]) key_id_d = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_evt_q <= 1'b0;
      key_id_q  <= 2'd0;
    end else begin
      key_evt_q <= key_evt_d;
      key_id_q  <= key_id_d;
    end
  end

  assign key_evt = key_evt_q;
  assign key_id  = key_id_q;
endmodule
